// File: rtl/in_port_mux_reg_pkg.sv
// Shared constants for the registered input-port selector: default sizing,
// status-address encoding, status-word layout and the idle output value.
package in_port_mux_reg_pkg;

    localparam int unsigned DEF_N_CH       = 13;
    localparam int unsigned DEF_W          = 8;

    // Bit of the status word that reports "some channel has unread data".
    localparam int unsigned STATUS_ANY_BIT = 0;

    // Value every output bit takes when nothing valid is selected.
    localparam logic        OUT_ZERO_BIT   = 1'b0;

    // The status word sits at the address just past the last channel.
    function automatic int unsigned status_sel(input int unsigned n_ch);
        return n_ch;
    endfunction

endpackage

// File: rtl/in_port_mux_reg_chan.sv
// One channel: live register, coherent read-bank copy, dirty and pending bits.
module in_port_chan_reg
    import in_port_mux_reg_pkg::*;
#(
    parameter int unsigned W = DEF_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] din,
    input  logic         load,
    input  logic         snap,
    input  logic         rd_clr,
    output logic [W-1:0] rb,
    output logic         pending
);

    logic [W-1:0] live_d, live_q;
    logic [W-1:0] rb_d,   rb_q;
    logic         dirty_d, dirty_q;
    logic         pending_d, pending_q;

    // Next-state: a load landing with a snap is bypassed straight into the read bank.
    always_comb begin
        live_d    = live_q;
        rb_d      = rb_q;
        dirty_d   = dirty_q;
        pending_d = pending_q;

        if (load) begin
            live_d = din;
        end else begin
            live_d = live_q;
        end

        if (snap) begin
            rb_d    = live_d;
            dirty_d = 1'b0;
        end else if (load) begin
            rb_d    = rb_q;
            dirty_d = 1'b1;
        end else begin
            rb_d    = rb_q;
            dirty_d = dirty_q;
        end

        // A snap that publishes new data beats a read clearing the flag.
        if (snap && (dirty_q || load)) begin
            pending_d = 1'b1;
        end else if (rd_clr) begin
            pending_d = 1'b0;
        end else begin
            pending_d = pending_q;
        end
    end

    // Channel state registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            live_q    <= {W{1'b0}};
            rb_q      <= {W{1'b0}};
            dirty_q   <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            live_q    <= live_d;
            rb_q      <= rb_d;
            dirty_q   <= dirty_d;
            pending_q <= pending_d;
        end
    end

    assign rb      = rb_q;
    assign pending = pending_q;

endmodule

// File: rtl/in_port_mux_reg.sv
// Registered input-port selector: per-channel live/read-bank registers,
// snapshot for tear-free multi-byte reads, status word and sticky select error.
module in_port_mux_reg
    import in_port_mux_reg_pkg::*;
#(
    parameter int unsigned N_CH  = DEF_N_CH,
    parameter int unsigned W     = DEF_W,
    parameter int unsigned SEL_W = $clog2(N_CH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_CH*W-1:0] ch_data,
    input  logic [N_CH-1:0]   ch_load,
    input  logic              snap,
    input  logic [SEL_W-1:0]  sel,
    input  logic              rd_strobe,
    output logic [W-1:0]      sal,
    output logic              rd_valid,
    output logic [N_CH-1:0]   pending,
    output logic              sel_err
);

    localparam logic [SEL_W-1:0] STATUS_SEL = SEL_W'(status_sel(N_CH));

    logic [W-1:0]    rb_s [N_CH];
    logic [N_CH-1:0] pending_s;
    logic [N_CH-1:0] rd_clr_s;
    logic [W-1:0]    status_s;

    logic [W-1:0]    sal_d, sal_q;
    logic            rd_valid_d, rd_valid_q;
    logic            sel_err_d, sel_err_q;

    // Per-channel read-clear: a strobe addressed to that channel.
    always_comb begin
        rd_clr_s = {N_CH{1'b0}};
        for (int k = 0; k < N_CH; k++) begin
            rd_clr_s[k] = rd_strobe && (sel == SEL_W'(k));
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_chan
        in_port_chan_reg #(.W(W)) u_chan (
            .clk     (clk),
            .reset   (reset),
            .din     (ch_data[k*W +: W]),
            .load    (ch_load[k]),
            .snap    (snap),
            .rd_clr  (rd_clr_s[k]),
            .rb      (rb_s[k]),
            .pending (pending_s[k])
        );
    end

    // Status word: only the "any pending" bit is populated.
    always_comb begin
        status_s                 = {W{OUT_ZERO_BIT}};
        status_s[STATUS_ANY_BIT] = |pending_s;
    end

    // Output mux, read-valid pulse and sticky illegal-select flag.
    always_comb begin
        sal_d      = {W{OUT_ZERO_BIT}};
        sel_err_d  = sel_err_q;
        rd_valid_d = rd_strobe;
        if (sel < STATUS_SEL) begin
            for (int k = 0; k < N_CH; k++) begin
                if (sel == SEL_W'(k)) begin
                    sal_d = rb_s[k];
                end else begin
                    sal_d = sal_d;
                end
            end
        end else if (sel == STATUS_SEL) begin
            sal_d = status_s;
        end else begin
            sal_d     = {W{OUT_ZERO_BIT}};
            sel_err_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sal_q      <= {W{1'b0}};
            rd_valid_q <= 1'b0;
            sel_err_q  <= 1'b0;
        end else begin
            sal_q      <= sal_d;
            rd_valid_q <= rd_valid_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign sal      = sal_q;
    assign rd_valid = rd_valid_q;
    assign sel_err  = sel_err_q;
    assign pending  = pending_s;

endmodule

// File: tb/tb_in_port_mux_reg.sv
// Directed bench for in_port_mux_reg: a 13x8 instance and a 4x16 instance.
module tb_in_port_mux_reg;

    logic clk;
    int   total;
    int   bad;

    // 13-channel, 8-bit instance
    logic          a_reset;
    logic [103:0]  a_data;
    logic [12:0]   a_load;
    logic          a_snap;
    logic [3:0]    a_sel;
    logic          a_rd;
    logic [7:0]    a_sal;
    logic          a_rd_valid;
    logic [12:0]   a_pending;
    logic          a_sel_err;

    // 4-channel, 16-bit instance
    logic          b_reset;
    logic [63:0]   b_data;
    logic [3:0]    b_load;
    logic          b_snap;
    logic [2:0]    b_sel;
    logic          b_rd;
    logic [15:0]   b_sal;
    logic          b_rd_valid;
    logic [3:0]    b_pending;
    logic          b_sel_err;

    logic [7:0]    qa [$];
    logic [15:0]   qb [$];

    in_port_mux_reg #(.N_CH(13), .W(8)) dut_a (
        .clk(clk), .reset(a_reset), .ch_data(a_data), .ch_load(a_load),
        .snap(a_snap), .sel(a_sel), .rd_strobe(a_rd), .sal(a_sal),
        .rd_valid(a_rd_valid), .pending(a_pending), .sel_err(a_sel_err)
    );

    in_port_mux_reg #(.N_CH(4), .W(16)) dut_b (
        .clk(clk), .reset(b_reset), .ch_data(b_data), .ch_load(b_load),
        .snap(b_snap), .sel(b_sel), .rd_strobe(b_rd), .sal(b_sal),
        .rd_valid(b_rd_valid), .pending(b_pending), .sel_err(b_sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one edge, land 1 time unit after it, and drop all strobes.
    task automatic tick();
        @(posedge clk);
        #1;
        a_load = 13'h0; a_snap = 1'b0; a_rd = 1'b0;
        b_load = 4'h0;  b_snap = 1'b0; b_rd = 1'b0;
    endtask

    task automatic load_a(input int ch, input logic [7:0] v);
        a_data[ch*8 +: 8] = v;
        a_load[ch]        = 1'b1;
    endtask

    task automatic load_b(input int ch, input logic [15:0] v);
        b_data[ch*16 +: 16] = v;
        b_load[ch]          = 1'b1;
    endtask

    task automatic rd_a(input string tag, input int s, input logic [7:0] exp);
        a_sel = 4'(s);
        a_rd  = 1'b1;
        qa.push_back(exp);
        tick();
        chk(tag, {24'h0, a_sal}, {24'h0, qa.pop_front()});
        chk({tag, "_rdv"}, {31'h0, a_rd_valid}, 32'h1);
    endtask

    task automatic rd_b(input string tag, input int s, input logic [15:0] exp);
        b_sel = 3'(s);
        b_rd  = 1'b1;
        qb.push_back(exp);
        tick();
        chk(tag, {16'h0, b_sal}, {16'h0, qb.pop_front()});
        chk({tag, "_rdv"}, {31'h0, b_rd_valid}, 32'h1);
    endtask

    initial begin
        total = 0; bad = 0;
        a_reset = 1'b1; a_data = '0; a_load = '0; a_snap = 1'b0; a_sel = 4'h0; a_rd = 1'b0;
        b_reset = 1'b1; b_data = '0; b_load = '0; b_snap = 1'b0; b_sel = 3'h0; b_rd = 1'b0;
        tick(); tick();
        a_reset = 1'b0; b_reset = 1'b0;
        tick();

        // Reset state
        chk("rst_sal",     {24'h0, a_sal},      32'h0);
        chk("rst_pending", {19'h0, a_pending},  32'h0);
        chk("rst_selerr",  {31'h0, a_sel_err},  32'h0);
        chk("rst_rdv",     {31'h0, a_rd_valid}, 32'h0);

        // Basic read
        load_a(3, 8'h45); tick();
        chk("pend_before_snap", {19'h0, a_pending}, 32'h0);
        a_snap = 1'b1; tick();
        chk("pend3_set", {19'h0, a_pending}, 32'h0008);
        rd_a("rd_ch3", 3, 8'h45);
        chk("pend3_clr", {19'h0, a_pending}, 32'h0);
        tick();
        chk("rdv_pulse_end", {31'h0, a_rd_valid}, 32'h0);

        // Coherence: a later load without snap must not leak into reads
        load_a(0, 8'h59); load_a(1, 8'h59); load_a(2, 8'h23); tick();
        a_snap = 1'b1; tick();
        load_a(0, 8'h00); tick();
        rd_a("coh_ch0", 0, 8'h59);
        rd_a("coh_ch1", 1, 8'h59);
        rd_a("coh_ch2", 2, 8'h23);
        chk("coh_pend", {19'h0, a_pending}, 32'h0);

        // Load and snap together: bypass; ch0 is still dirty from the late load
        load_a(5, 8'hA1); a_snap = 1'b1; tick();
        chk("sim_pend", {19'h0, a_pending}, 32'h0021);
        rd_a("sim_ch5", 5, 8'hA1);
        chk("sim_pend5_clr", {19'h0, a_pending}, 32'h0001);
        rd_a("sim_ch0", 0, 8'h00);
        load_a(5, 8'h77); tick();
        a_snap = 1'b1;
        rd_a("snap_rd_ch5", 5, 8'hA1);
        chk("set_wins", {19'h0, a_pending}, 32'h0020);
        rd_a("rd_ch5_new", 5, 8'h77);
        chk("pend5_clr2", {19'h0, a_pending}, 32'h0);

        // Status word
        load_a(7, 8'h11); tick();
        a_snap = 1'b1; tick();
        rd_a("status_any", 13, 8'h01);
        chk("status_noclr", {19'h0, a_pending}, 32'h0080);
        rd_a("rd_ch7", 7, 8'h11);
        rd_a("status_none", 13, 8'h00);
        chk("selerr_legal", {31'h0, a_sel_err}, 32'h0);

        // Illegal select: zero output, sticky error
        rd_a("illegal_sal", 14, 8'h00);
        chk("selerr_set", {31'h0, a_sel_err}, 32'h1);
        rd_a("after_illegal", 3, 8'h45);
        chk("selerr_sticky", {31'h0, a_sel_err}, 32'h1);

        // Asynchronous reset mid-run
        load_a(9, 8'h5A); tick();
        a_snap = 1'b1; tick();
        chk("pre_rst_pend", {19'h0, a_pending}, 32'h0200);
        a_reset = 1'b1;
        #2;
        chk("arst_sal",    {24'h0, a_sal},     32'h0);
        chk("arst_pend",   {19'h0, a_pending}, 32'h0);
        chk("arst_selerr", {31'h0, a_sel_err}, 32'h0);
        a_reset = 1'b0;
        load_a(2, 8'hC3); tick();
        a_snap = 1'b1; tick();
        rd_a("post_rst_ch2", 2, 8'hC3);
        rd_a("post_rst_ch3", 3, 8'h00);

        // 4-channel, 16-bit instance
        load_b(3, 16'hBEEF); tick();
        b_snap = 1'b1; tick();
        chk("b_pend", {28'h0, b_pending}, 32'h8);
        rd_b("b_status_any", 4, 16'h0001);
        rd_b("b_ch3", 3, 16'hBEEF);
        rd_b("b_status_none", 4, 16'h0000);
        chk("b_selerr_legal", {31'h0, b_sel_err}, 32'h0);
        rd_b("b_illegal", 5, 16'h0000);
        chk("b_selerr", {31'h0, b_sel_err}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/in_port_mux_reg.md
# in_port_mux_reg

Parametrised, registered successor to the PicoBlaze input-port selector in the RTC controller. It holds one live register per input channel, loaded by a producer strobe. A snapshot pulse copies every live register into a coherent read bank, so multi-byte RTC time and date reads never tear. The block drives a registered output byte selected by the port address and keeps per-channel "new data" flags that clear when the processor reads the channel.

## Interface
- N_CH, 13: number of data channels; legal range 2..16.
- W, 8: channel and output data width.
- SEL_W, $clog2(N_CH+1): select width, derived; not to be overridden.
- clk  input  1  system clock; all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- ch_data  input  N_CH*W  flattened channel data; channel k occupies bits [k*W +: W].
- ch_load  input  N_CH  per-channel load strobe, one cycle per update.
- snap  input  1  single-cycle pulse; copies all live registers into the read bank.
- sel  input  SEL_W  channel select (port_id slice).
- rd_strobe  input  1  processor read strobe, qualified by sel.
- sal  output  W  registered selected data.
- rd_valid  output  1  one-cycle pulse, one cycle after an accepted rd_strobe.
- pending  output  N_CH  per-channel unread-update flags.
- sel_err  output  1  registered flag for an illegal select; sticky until reset.

## Operation
- Live bank: live[k] <= ch_data[k] when ch_load[k]=1; otherwise it holds.
- Read bank: when snap=1, rb[k] <= the value live[k] takes this edge. If ch_load[k] and snap coincide, the new ch_data[k] is captured (bypass). Otherwise rb holds.
- Output mux, every cycle:
  - sel < N_CH: sal <= rb[sel].
  - sel == N_CH: sal <= status word, the OR of the pending bits zero-extended or truncated to W (bit 0 = any pending), {W-1 zeros, |pending}.
  - sel > N_CH: sal <= 0 and sel_err <= 1. Output is never X.
- Pending flags, channel k:
  - Set when snap=1 and live[k] changed since the previous snap (tracked by an internal dirty[k] bit set on ch_load[k] and cleared on snap).
  - Cleared when rd_strobe=1 and sel==k.
  - Set and clear in the same cycle: set wins.
- rd_valid <= rd_strobe, for any sel, including illegal ones.
- Reading the status address (sel==N_CH) clears no flags.

## Timing
- Reset values: live, rb, sal = 0; pending, dirty, rd_valid, sel_err = 0.
- sel to sal latency is 1 cycle: sal at edge t+1 reflects sel and rb sampled at edge t. Back-to-back reads at different sel values are legal every cycle.
- ch_load to sal requires a snap: load at t, snap at t or later, read issued no earlier than the cycle after the snap.
- pending updates at the edge following the snap or read.
- Reset asserted mid-operation clears all state immediately (asynchronous). The first load is accepted on the first edge after reset deasserts.

## Structure
- Shared package holds the status-address encoding (N_CH), the status-word bit layout, and the zero/default output constant.
- One sub-module is natural: in_port_chan_reg (the live register, read-bank register, dirty bit and pending bit for one channel), instanced N_CH times via generate. The top level holds the output mux, the status word, rd_valid and sel_err.

## Test plan
- Reset: assert reset mid-run with non-zero data -> sal=0, pending=0, sel_err=0 asynchronously; the first load after release is captured.
- Basic read (N_CH=13, W=8): load ch3=8'h45, snap, then sel=3 with rd_strobe -> sal=8'h45 and rd_valid=1 one cycle later, pending[3] 1->0.
- Coherence: load ch0..ch2=8'h59,8'h59,8'h23, snap, then load ch0=8'h00 without a snap -> reads of ch0..ch2 still return 59,59,23.
- Simultaneous events: ch_load[5]=1 and snap in the same cycle with data 8'hA1 -> rb[5]=8'hA1. A read of ch5 in the same cycle as a snap that sets pending[5] -> pending[5] remains 1.
- Status and illegal select: pending[7]=1, sel=13 -> sal=8'h01 and pending unchanged. sel=14 -> sal=8'h00, sel_err=1 and sticky until reset.
- Parametrisation: N_CH=4, W=16. Load ch3=16'hBEEF, snap, read sel=3 -> sal=16'hBEEF; status address is sel=4.
